ultra_sonic: RTL and testbench
==============================

Name: ultra_sonic

Overview:
Driver for an HC-SR04-style ultrasonic ranger on GPIO. The block fires a trigger pulse, then measures the width of the echo pulse in clock cycles, then holds off before the next trigger. It runs autonomously and exposes the latest echo width to the Nios-facing read port, with a one-cycle valid strobe per new measurement.

Parameters:
TRIG_CYCLES, 500, cycles trigger is held high per ping (10 us at 50 MHz)
ECHO_TIMEOUT, 1000000, max cycles to wait for echo rise before abandoning ping
STALL_CYCLES, 600, hold-off cycles after a ping before the next trigger

Ports:
clk  input  1  system clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
echo  input  1  echo pin from sensor (asynchronous)
trigger  output  1  trigger pin to sensor
read_data  output  32  width of last completed echo pulse, in clk cycles
read_data_valid  output  1  one-cycle strobe: read_data just updated

Behaviour:
- One clock; reset is synchronous and active-high. All state is updated on the rising edge of clk only.
- Reset: state=TRIGGER, counters=0, trigger=0, read_data=0, read_data_valid=0.
- FSM states: TRIGGER, WAIT_ECHO, MEASURE, STALL.
- TRIGGER: trigger=1 for exactly TRIG_CYCLES cycles, starting the first cycle after reset deasserts. Then go to WAIT_ECHO with trigger=0. Echo is ignored in this state.
- WAIT_ECHO: trigger=0 and the wait counter increments each cycle.
  - echo sampled 1: set count=1 and go to MEASURE.
  - ECHO_TIMEOUT cycles elapse with no echo: go to STALL. No valid strobe; read_data is unchanged.
  - An X or Z on echo counts as 0 and must not cause a transition.
- MEASURE:
  - echo=1: count=count+1, saturating at 32'hFFFF_FFFF (no wrap).
  - echo=0: read_data<=count, read_data_valid<=1 for exactly one cycle, go to STALL.
  - An echo high for N sampled cycles yields read_data=N. The strobe rises the cycle after the first low sample.
- STALL: trigger=0 for STALL_CYCLES cycles, then go to TRIGGER. Echo activity here is ignored. An echo still high on entry never extends the previous measurement.
- read_data holds its value between measurements and is never cleared except by reset.
- read_data_valid is 0 except for the single strobe cycle.
- Reset in any state, including mid-MEASURE, discards the in-progress count and restarts from TRIGGER.
- Zero-width echo (asserted and released between samples) is not seen. The ping then times out.
- Counters are sized to hold the largest parameter value. The measurement counter is 32 bits.

Optional Feature:
Macro ULTRA_SONIC_ECHO_SYNC_EN.
- Defined: echo passes through a 2-flop synchronizer before the FSM. Every echo-driven transition and read_data_valid lags the pin by 2 extra cycles. Measured width is unchanged, since both edges are delayed equally.
- Undefined: echo is sampled directly by the FSM. This is intended for simulation or when echo is already synchronous to clk.
- Test plan values assume the macro is undefined.

Test Plan:
1. Release reset → trigger=1 for exactly 500 consecutive cycles, then 0. read_data=0 and read_data_valid=0 throughout.
2. Echo high for 150 cycles, starting 1000 cycles into WAIT_ECHO → read_data=150 and read_data_valid=1 for one cycle, the cycle after echo falls. Trigger rises again 600 cycles later.
3. Repeat pings with echo widths 0, 300, 600, …, 4200 cycles. Width 0 → timeout with no strobe, read_data keeps its previous value. Each nonzero width → read_data equals that width, with one strobe per ping.
4. No echo at all → after 1,000,000 WAIT_ECHO cycles go to STALL with no strobe. Trigger reasserts 600 cycles later.
5. Assert reset for one cycle in the middle of a 2000-cycle echo → read_data=0, no strobe, trigger high the next cycle for 500 cycles.
6. Echo pulses during TRIGGER and STALL → no count, no strobe, read_data unchanged.

Source files
------------

// File: rtl/ultra_sonic.sv
// HC-SR04 ranger driver: trigger pulse, echo width in clk cycles, hold-off; strobe per new width.
// Define ULTRA_SONIC_ECHO_SYNC_EN to put a 2-flop synchronizer on echo (adds 2 cycles, width unchanged).
module ultra_sonic #(
  parameter int unsigned TRIG_CYCLES  = 500,
  parameter int unsigned ECHO_TIMEOUT = 1000000,
  parameter int unsigned STALL_CYCLES = 600
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        echo,
  output logic        trigger,
  output logic [31:0] read_data,
  output logic        read_data_valid
);

  localparam int unsigned MAX_TS  = (TRIG_CYCLES > STALL_CYCLES) ? TRIG_CYCLES : STALL_CYCLES;
  localparam int unsigned CNT_MAX = (MAX_TS > ECHO_TIMEOUT) ? MAX_TS : ECHO_TIMEOUT;
  localparam int          CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] TRIG_END  = CW'(TRIG_CYCLES);
  localparam logic [CW-1:0] WAIT_END  = CW'(ECHO_TIMEOUT - 1);
  localparam logic [CW-1:0] STALL_END = CW'(STALL_CYCLES);

  typedef enum logic [1:0] {TRIGGER, WAIT_ECHO, MEASURE, STALL} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [31:0]   meas, meas_nxt;
  logic [31:0]   read_data_nxt;
  logic          read_data_valid_nxt;
  logic          echo_s;

`ifdef ULTRA_SONIC_ECHO_SYNC_EN
  logic [1:0] echo_sync;

  always_ff @(posedge clk) begin
    if (reset) echo_sync <= 2'b00;
    else       echo_sync <= {echo_sync[0], echo};
  end

  assign echo_s = echo_sync[1];
`else
  assign echo_s = echo;
`endif

  // trigger is registered from the next state so it is low during reset and
  // rises on the first clock after reset releases
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= TRIGGER;
      cnt             <= '0;
      meas            <= '0;
      trigger         <= 1'b0;
      read_data       <= '0;
      read_data_valid <= 1'b0;
    end else begin
      state           <= state_nxt;
      cnt             <= cnt_nxt;
      meas            <= meas_nxt;
      trigger         <= (state_nxt == TRIGGER);
      read_data       <= read_data_nxt;
      read_data_valid <= read_data_valid_nxt;
    end
  end

  // In TRIGGER and STALL cnt counts cycles already spent (entry value 1),
  // except right after reset where trigger has not yet gone high (cnt 0).
  always_comb begin
    state_nxt           = state;
    cnt_nxt             = cnt;
    meas_nxt            = meas;
    read_data_nxt       = read_data;
    read_data_valid_nxt = 1'b0;
    case (state)
      TRIGGER: begin
        if (cnt >= TRIG_END) begin
          state_nxt = WAIT_ECHO;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      WAIT_ECHO: begin
        // an unknown echo is not 1, so it never starts a measurement
        if (echo_s == 1'b1) begin
          state_nxt = MEASURE;
          meas_nxt  = 32'd1;
          cnt_nxt   = '0;
        end else if (cnt >= WAIT_END) begin
          state_nxt = STALL;
          cnt_nxt   = CW'(1);
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      MEASURE: begin
        if (echo_s == 1'b1) begin
          if (meas != 32'hFFFF_FFFF) meas_nxt = meas + 32'd1;
        end else begin
          read_data_nxt       = meas;
          read_data_valid_nxt = 1'b1;
          state_nxt           = STALL;
          cnt_nxt             = CW'(1);
        end
      end
      STALL: begin
        if (cnt >= STALL_END) begin
          state_nxt = TRIGGER;
          cnt_nxt   = CW'(1);
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = TRIGGER;
        cnt_nxt   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_ultra_sonic.sv
// Randomized bench for ultra_sonic: per-ping expectations derived from the ping timing rules.
module tb_ultra_sonic;

  localparam int TRIG  = 500;
  localparam int TMO   = 2000;
  localparam int STALL = 600;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        echo = 1'b0;
  logic        trigger;
  logic [31:0] read_data;
  logic        read_data_valid;

  int total = 0;
  int bad = 0;
  longint exp_rd = 0;

  ultra_sonic #(
    .TRIG_CYCLES (TRIG),
    .ECHO_TIMEOUT(TMO),
    .STALL_CYCLES(STALL)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .echo           (echo),
    .trigger        (trigger),
    .read_data      (read_data),
    .read_data_valid(read_data_valid)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input longint got, input longint exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Entered at a negedge where trigger has just been seen high. Echo goes high
  // d cycles after trigger falls and stays high for w cycles (w=0: no echo).
  task automatic ping(input int d, input int w, input bit noise);
    int highs, quiet_err, nstrobe, strobe_at, rise_at, exp_strobe_at, exp_stall;
    longint rd_at_strobe;
    bit hit;
    highs = 0;
    quiet_err = 0;
    while (trigger === 1'b1 && highs < TRIG + 10) begin
      highs++;
      if (read_data_valid !== 1'b0 || longint'(read_data) != exp_rd) quiet_err++;
      echo = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      step();
    end
    check_eq("trig_len", highs, TRIG);
    check_eq("trig_quiet", quiet_err, 0);
    echo = 1'b0;

    hit = (w > 0) && (d < TMO);
    exp_strobe_at = hit ? d + w + 1 : -1;
    exp_stall     = hit ? d + w + 1 : TMO;
    nstrobe = 0;
    strobe_at = -1;
    rise_at = -1;
    rd_at_strobe = -1;
    for (int k = 0; k < exp_stall + STALL + 50; k++) begin
      if (read_data_valid === 1'b1) begin
        nstrobe++;
        if (strobe_at < 0) begin
          strobe_at = k;
          rd_at_strobe = longint'(read_data);
        end
      end
      if (trigger === 1'b1) begin
        rise_at = k;
        break;
      end
      if (k >= d && k < d + w)               echo = 1'b1;
      else if (noise && k >= exp_stall)      echo = 1'($urandom_range(0, 1));
      else                                   echo = 1'b0;
      step();
    end
    check_eq("strobes", nstrobe, hit ? 1 : 0);
    if (hit) begin
      check_eq("strobe_at", strobe_at, exp_strobe_at);
      check_eq("width", rd_at_strobe, w);
      exp_rd = w;
    end
    check_eq("rise_at", rise_at, exp_stall + STALL);
    check_eq("rd_hold", longint'(read_data), exp_rd);
  endtask

  task automatic reset_mid();
    int g;
    g = 0;
    while (trigger === 1'b1 && g < TRIG + 10) begin
      g++;
      step();
    end
    echo = 1'b0;
    repeat (100) step();
    echo = 1'b1;
    repeat (1000) step();
    reset = 1'b1;
    step();
    check_eq("rst_mid_trig", trigger, 0);
    check_eq("rst_mid_rd", longint'(read_data), 0);
    check_eq("rst_mid_vld", read_data_valid, 0);
    exp_rd = 0;
    reset = 1'b0;
    echo = 1'b0;
    step();
    check_eq("rst_mid_rise", trigger, 1);
  endtask

  initial begin
    repeat (3) step();
    check_eq("rst_trig", trigger, 0);
    check_eq("rst_rd", longint'(read_data), 0);
    check_eq("rst_vld", read_data_valid, 0);
    reset = 1'b0;
    step();
    check_eq("first_rise", trigger, 1);

    ping(1000, 150, 1'b0);
    for (int w = 0; w <= 4200; w += 300) ping($urandom_range(0, 100), w, 1'b0);
    ping(0, 0, 1'b0);
    ping(TMO - 1, 40, 1'b0);
    ping(TMO, 40, 1'b0);
    ping(0, 1, 1'b0);
    for (int i = 0; i < 5; i++) ping($urandom_range(0, TMO + 100), $urandom_range(0, 400), 1'b1);
    reset_mid();
    ping(50, 77, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
